// File: rtl/reg_hazard_unit_pkg.sv
// hazard_pkg: shared types and constants for reg_hazard_unit; HAZ_WB_BYPASS_EN selects read-first regfile bypass
package hazard_pkg;
  localparam int REG_NUM_W = 5;
  localparam logic [REG_NUM_W-1:0] ZERO_REG = '0;
`ifdef HAZ_WB_BYPASS_EN
  localparam bit WB_BYPASS = 1'b1;
`else
  localparam bit WB_BYPASS = 1'b0;
`endif
  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_HOLD = 2'b11
  } fwd_sel_t;
  typedef struct packed {
    logic                 valid;
    logic [REG_NUM_W-1:0] num;
    logic                 reg_write;
    logic                 load;
  } dest_entry_t;
  function automatic logic is_producer(dest_entry_t e);
    return e.valid & e.reg_write & (e.num != ZERO_REG);
  endfunction
endpackage

// File: rtl/reg_hazard_unit_if.sv
// reg_hazard_unit_if: ID-stage hazard request and forwarding/writeback response bundle
interface reg_hazard_unit_if #(parameter int REG_W = 5);
  logic             ext_stall;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_rs_num;
  logic [REG_W-1:0] id_rt_num;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_write_num;
  logic             id_reg_write;
  logic             id_mem_to_reg;
  logic             stall;
  logic [1:0]       ex_fwd_a;
  logic [1:0]       ex_fwd_b;
  logic [REG_W-1:0] wb_write_num;
  logic             wb_reg_write;
  modport master (
    output ext_stall, flush, id_valid, id_rs_num, id_rt_num, id_use_rs, id_use_rt,
           id_write_num, id_reg_write, id_mem_to_reg,
    input  stall, ex_fwd_a, ex_fwd_b, wb_write_num, wb_reg_write
  );
  modport slave (
    input  ext_stall, flush, id_valid, id_rs_num, id_rt_num, id_use_rs, id_use_rt,
           id_write_num, id_reg_write, id_mem_to_reg,
    output stall, ex_fwd_a, ex_fwd_b, wb_write_num, wb_reg_write
  );
endinterface

// File: rtl/reg_hazard_unit_src_cmp.sv
// hazard_src_cmp: matches one ID source register against the in-flight destinations, youngest first
module hazard_src_cmp
  import hazard_pkg::*;
(
  input  logic                 use_src,
  input  logic [REG_NUM_W-1:0] src,
  input  dest_entry_t          ex,
  input  dest_entry_t          mem,
  input  dest_entry_t          wb,
  output logic                 load_use,
  output fwd_sel_t             fwd_sel
);
  logic ex_hit, mem_hit, wb_hit;
  always_comb begin
    ex_hit   = use_src & is_producer(ex) & (ex.num == src);
    mem_hit  = use_src & is_producer(mem) & (mem.num == src);
    wb_hit   = use_src & WB_BYPASS & is_producer(wb) & (wb.num == src);
    load_use = ex_hit & ex.load;
    fwd_sel  = ex_hit ? (ex.load ? FWD_RF : FWD_MEM) :
               mem_hit ? FWD_WB :
               wb_hit ? FWD_HOLD : FWD_RF;
  end
endmodule

// File: rtl/reg_hazard_unit.sv
// reg_hazard_unit: tracks destinations through EX/MEM/WB, raises load-use stall, registers EX forward selects.
// HAZ_WB_BYPASS_EN adds the WB hold-register forward code for a read-first regfile.
module reg_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31
) (
  input logic               clk,
  input logic               rst,
  reg_hazard_unit_if.slave  hz
);
  dest_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  fwd_sel_t    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
  logic        lu_a, lu_b, bubble;
  hazard_src_cmp u_cmp_rs (
    .use_src (hz.id_valid & hz.id_use_rs),
    .src     (hz.id_rs_num),
    .ex      (ex_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .load_use(lu_a),
    .fwd_sel (sel_a)
  );
  hazard_src_cmp u_cmp_rt (
    .use_src (hz.id_valid & hz.id_use_rt),
    .src     (hz.id_rt_num),
    .ex      (ex_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .load_use(lu_b),
    .fwd_sel (sel_b)
  );
  always_comb begin
    hz.stall = hz.id_valid & ~hz.flush & (lu_a | lu_b);
    bubble   = hz.flush | hz.stall;
    ex_d     = hz.ext_stall ? ex_q : bubble ? '0 :
               '{valid: hz.id_valid, num: hz.id_write_num,
                 reg_write: hz.id_reg_write, load: hz.id_mem_to_reg};
    mem_d    = hz.ext_stall ? mem_q : ex_q;
    wb_d     = hz.ext_stall ? wb_q : mem_q;
    fwd_a_d  = hz.ext_stall ? fwd_a_q : bubble ? FWD_RF : sel_a;
    fwd_b_d  = hz.ext_stall ? fwd_b_q : bubble ? FWD_RF : sel_b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
    if (!rst) assert (LINK_REG < (1 << REG_W));
  end
  assign hz.ex_fwd_a     = fwd_a_q;
  assign hz.ex_fwd_b     = fwd_b_q;
  assign hz.wb_write_num = wb_q.num;
  assign hz.wb_reg_write = is_producer(wb_q);
endmodule
